serial_word_collector: RTL and testbench
========================================

# serial_word_collector

Deserialising stage downstream of the serial complement block. It takes a qualified LSB-first bit stream with a start-of-word marker and assembles WIDTH-bit words. Completed words sit in a small output FIFO and are released over a valid/ready handshake. Framing errors and overflow drops are flagged so the consumer never sees a corrupted word.

## Interface
- WIDTH, 4: bits per word; WIDTH >= 2.
- DEPTH, 2: output FIFO entries; power of 2, >= 2.
- clk  input  1  rising-edge clock.
- set  input  1  reset; asynchronous, active-high.
- bit_in  input  1  serial data, LSB first.
- bit_vld  input  1  bit_in is valid this cycle.
- sof  input  1  start of word; meaningful only with bit_vld=1.
- word_out  output  WIDTH  head-of-FIFO word; 0 when word_vld=0.
- word_vld  output  1  word_out is valid.
- word_rdy  input  1  consumer accepts word_out.
- busy  output  1  partial word in progress (state SHIFT).
- err_frame  output  1  one-cycle pulse on a framing error.
- drop  output  1  one-cycle pulse when a completed word is lost to a full FIFO.

## Operation
- FSM states IDLE and SHIFT; bit counter cnt is clog2(WIDTH) bits wide; shift register sr is WIDTH bits wide.
- IDLE, bit_vld & sof: sr[0]=bit_in, cnt=1 -> SHIFT.
- IDLE, bit_vld & !sof: bit ignored, err_frame pulse, stay IDLE.
- SHIFT, bit_vld & !sof: sr[cnt]=bit_in, cnt++.
  - If this bit is sr[WIDTH-1], the word {bit_in, sr[WIDTH-2:0]} commits to the FIFO and the FSM returns to IDLE.
- SHIFT, bit_vld & sof: the partial word is discarded and err_frame pulses. The bit restarts framing as bit 0, with cnt=1 and the FSM staying in SHIFT.
- bit_vld=0: no state change. Gaps are allowed anywhere within a word.
- Commit with FIFO full and no pop that cycle: word discarded, drop pulses.
- Pop happens when word_vld & word_rdy. Push and pop in the same cycle are both honoured, including when the FIFO is full.
- Read and write pointers wrap modulo DEPTH. An extra pointer bit distinguishes full from empty.

## Timing
- All outputs reset to 0; FSM resets to IDLE; FIFO resets to empty. Reset is asynchronous on assertion and synchronous on release.
- Reset asserted mid-word or with the FIFO occupied discards everything. No output pulses occur on reset.
- Latency: word_vld rises on the cycle after the final bit's clock edge when the FIFO was empty. There is no combinational bypass.
- A full word needs a minimum of WIDTH cycles. Back-to-back words sustain 1 bit/cycle with no dead cycle.
- word_out and word_vld are registered or FIFO-head outputs. They hold stable while word_vld=1 & word_rdy=0.
- err_frame and drop are registered, asserted for exactly one cycle per event, and may assert in the same cycle.
- busy=1 exactly while the FSM is in SHIFT.

## Configuration
- SWC_DROP_CNT_EN defined:
  - Adds output port drop_cnt (8 bits): a count of drop pulses that saturates at 255.
  - Reset value 0; cleared only by set.
- SWC_DROP_CNT_EN undefined: no drop_cnt port and no counter logic. The drop pulse is still present.

## Test plan
- WIDTH=4, word_rdy=1; send bits 0,1,0,1 (sof on first), one per cycle -> word_out=4'b1010 with word_vld=1 for one cycle, one cycle after the last bit.
- Send 1,1,0,0 with bit_vld low for 2 cycles between bits 2 and 3 -> word_out=4'b0011; busy high throughout the gap.
- Send 1,0 then a new sof with bits 0,0,0,1 -> err_frame pulses once; only 4'b1000 is delivered.
- word_rdy=0; send three words 4'h5, 4'h3, 4'h9 -> FIFO holds 5 and 3; drop pulses on the third word; drop_cnt=1 with SWC_DROP_CNT_EN. Then raise word_rdy -> 5 then 3 delivered.
- Full FIFO with word_rdy=1 on the cycle the next word commits -> no drop; words are delivered in order.
- Assert set after two bits of a word with one word queued -> all outputs are 0 immediately. After release, a fresh word 4'h6 is delivered correctly.

Source files
------------

// File: rtl/serial_word_collector_if.sv
// rtl/serial_word_collector_if.sv - serial bit input and word output handshake bundle
interface serial_word_collector_if #(
  parameter int WIDTH = 4
);
  logic             bit_in;
  logic             bit_vld;
  logic             sof;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             word_rdy;
  logic             busy;
  logic             err_frame;
  logic             drop;

  // Producer of bits and consumer of words.
  modport master (
    output bit_in, bit_vld, sof, word_rdy,
    input  word_out, word_vld, busy, err_frame, drop
  );

  // The collector itself.
  modport slave (
    input  bit_in, bit_vld, sof, word_rdy,
    output word_out, word_vld, busy, err_frame, drop
  );
endinterface

// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - LSB-first deserialiser with output FIFO; SWC_DROP_CNT_EN adds drop_cnt
module serial_word_collector #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   set,
  serial_word_collector_if.slave bus
`ifdef SWC_DROP_CNT_EN
  ,
  output logic [7:0]             drop_cnt
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             err_q, err_d;
  logic             drop_q, drop_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic             commit;
  logic [WIDTH-1:0] commit_word;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             push;

  // Framing FSM: collects bits into sr and flags a word as complete on its last bit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    err_d       = 1'b0;
    commit      = 1'b0;
    commit_word = '0;
    if (bus.bit_vld) begin
      case (state_q)
        IDLE: begin
          if (bus.sof) begin
            sr_d    = '0;
            sr_d[0] = bus.bit_in;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end else begin
            err_d = 1'b1;
          end
        end
        SHIFT: begin
          if (bus.sof) begin
            // A new start marker mid-word abandons the partial word and reframes.
            err_d   = 1'b1;
            sr_d    = '0;
            sr_d[0] = bus.bit_in;
            cnt_d   = CW'(1);
          end else begin
            sr_d[cnt_q] = bus.bit_in;
            if (cnt_q == CW'(WIDTH - 1)) begin
              commit      = 1'b1;
              commit_word = sr_d;
              cnt_d       = '0;
              state_d     = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO bookkeeping: simultaneous push and pop are both honoured, even when full.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !fifo_empty && bus.word_rdy;
    push       = commit && (!fifo_full || pop);
    drop_d     = commit && fifo_full && !pop;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = commit_word;
    end
  end

  // State, pointer, storage and pulse registers.
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      err_q    <= 1'b0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

`ifdef SWC_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped words, tracking the drop pulse edge for edge.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_d && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register, cleared only by reset.
  always_ff @(posedge clk or posedge set) begin
    if (set) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  // Outputs come straight from registers or the FIFO head, never from the inputs.
  always_comb begin
    bus.word_vld  = !fifo_empty;
    bus.word_out  = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    bus.busy      = (state_q == SHIFT);
    bus.err_frame = err_q;
    bus.drop      = drop_q;
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - randomized and directed bench with behavioural word model
module tb_serial_word_collector;
  localparam int W = 4;
  localparam int D = 2;

  logic clk;
  logic set;
  int   checks;
  int   errors;

  serial_word_collector_if #(.WIDTH(W)) bus ();

`ifdef SWC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  serial_word_collector #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .set (set),
    .bus (bus)
`ifdef SWC_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: word in progress as a bit count plus value, FIFO as a queue.
  bit           m_busy;
  int           m_n;
  logic [W-1:0] m_val;
  logic [W-1:0] m_q[$];
  bit           m_err;
  bit           m_drop;
  int           m_dcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0;
    m_n    = 0;
    m_val  = '0;
    m_q.delete();
    m_err  = 0;
    m_drop = 0;
    m_dcnt = 0;
  endtask

  // Predicts the state after the next rising edge from the inputs just applied.
  task automatic model_update();
    bit           commit;
    bit           pop;
    logic [W-1:0] cw;
    commit = 0;
    cw     = '0;
    m_err  = 0;
    m_drop = 0;
    pop    = (m_q.size() > 0) && (bus.word_rdy === 1'b1);
    if (bus.bit_vld) begin
      if (bus.sof) begin
        if (m_busy) m_err = 1;
        m_val    = '0;
        m_val[0] = bus.bit_in;
        m_n      = 1;
        m_busy   = 1;
      end else if (!m_busy) begin
        m_err = 1;
      end else begin
        m_val[m_n] = bus.bit_in;
        m_n++;
        if (m_n == W) begin
          commit = 1;
          cw     = m_val;
          m_busy = 0;
          m_n    = 0;
        end
      end
    end
    if (pop) void'(m_q.pop_front());
    if (commit) begin
      if (m_q.size() < D) begin
        m_q.push_back(cw);
      end else begin
        m_drop = 1;
        if (m_dcnt < 255) m_dcnt++;
      end
    end
  endtask

  task automatic compare();
    logic [W-1:0] exp_word;
    exp_word = (m_q.size() > 0) ? m_q[0] : '0;
    chk("word_vld", 32'(bus.word_vld), 32'(m_q.size() > 0));
    chk("word_out", 32'(bus.word_out), 32'(exp_word));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("err_frame", 32'(bus.err_frame), 32'(m_err));
    chk("drop", 32'(bus.drop), 32'(m_drop));
`ifdef SWC_DROP_CNT_EN
    chk("drop_cnt", 32'(drop_cnt), 32'(m_dcnt));
`endif
  endtask

  // One cycle: check outputs of the previous edge, apply new inputs, advance the model.
  task automatic step(input logic v, input logic b, input logic s, input logic r);
    @(negedge clk);
    compare();
    bus.bit_vld  = v;
    bus.bit_in   = b;
    bus.sof      = s;
    bus.word_rdy = r;
    model_update();
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r);
    logic [W-1:0] t;
    t = w;
    for (int i = 0; i < W; i++) begin
      step(1'b1, t[i], (i == 0), r);
    end
  endtask

  initial begin
    logic [W-1:0] t6;
    checks = 0;
    errors = 0;
    set = 1'b1;
    bus.bit_in = 1'b0;
    bus.bit_vld = 1'b0;
    bus.sof = 1'b0;
    bus.word_rdy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    set = 1'b0;
    chk("reset_vld", 32'(bus.word_vld), 32'd0);
    chk("reset_out", 32'(bus.word_out), 32'd0);
    chk("reset_busy", 32'(bus.busy), 32'd0);

    // Bits 0,1,0,1 -> 4'b1010 one cycle after the last bit, then gone.
    send_word(4'hA, 1'b1);
    step(0, 0, 0, 1);
    chk("t1_vld", 32'(bus.word_vld), 32'd1);
    chk("t1_word", 32'(bus.word_out), 32'hA);
    step(0, 0, 0, 1);
    chk("t1_popped", 32'(bus.word_vld), 32'd0);

    // Bits 1,1,0,0 with a two-cycle gap; busy holds through it.
    step(1, 1, 1, 1);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t2_busy_gap", 32'(bus.busy), 32'd1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t2_word", 32'(bus.word_out), 32'h3);

    // Partial 1,0 then a fresh sof word 0,0,0,1 -> one err_frame, only 4'b1000.
    step(1, 1, 1, 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    step(1, 0, 0, 1);
    chk("t3_err", 32'(bus.err_frame), 32'd1);
    step(1, 0, 0, 1);
    chk("t3_err_once", 32'(bus.err_frame), 32'd0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 1);
    chk("t3_word", 32'(bus.word_out), 32'h8);
    step(0, 0, 0, 1);
    chk("t3_only", 32'(bus.word_vld), 32'd0);

    // Consumer stalled: 5 and 3 queue, 9 is dropped.
    send_word(4'h5, 1'b0);
    send_word(4'h3, 1'b0);
    send_word(4'h9, 1'b0);
    step(0, 0, 0, 0);
    chk("t4_drop", 32'(bus.drop), 32'd1);
    chk("t4_head", 32'(bus.word_out), 32'h5);
`ifdef SWC_DROP_CNT_EN
    chk("t4_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    step(0, 0, 0, 1);
    chk("t4_first", 32'(bus.word_out), 32'h5);
    step(0, 0, 0, 1);
    chk("t4_second", 32'(bus.word_out), 32'h3);
    step(0, 0, 0, 1);
    chk("t4_empty", 32'(bus.word_vld), 32'd0);

    // Full FIFO, pop on the commit cycle: no drop, order kept.
    send_word(4'h5, 1'b0);
    send_word(4'h3, 1'b0);
    step(1, 0, 1, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 1);
    step(0, 0, 0, 0);
    chk("t5_no_drop", 32'(bus.drop), 32'd0);
    chk("t5_head", 32'(bus.word_out), 32'h3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("t5_next", 32'(bus.word_out), 32'hE);
    step(0, 0, 0, 1);

    // Reset mid-word with a word queued clears everything immediately.
    send_word(4'hC, 1'b0);
    step(1, 1, 1, 0);
    step(1, 0, 0, 0);
    #2;
    set = 1'b1;
    bus.bit_vld = 1'b0;
    bus.sof = 1'b0;
    model_reset();
    #1;
    chk("t6_vld", 32'(bus.word_vld), 32'd0);
    chk("t6_out", 32'(bus.word_out), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_err", 32'(bus.err_frame), 32'd0);
    chk("t6_drop", 32'(bus.drop), 32'd0);
    @(negedge clk);
    set = 1'b0;
    t6 = 4'h6;
    send_word(t6, 1'b1);
    step(0, 0, 0, 1);
    chk("t6_word", 32'(bus.word_out), 32'h6);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic v, b, s, r;
      v = ($urandom_range(0, 9) < 7);
      b = 1'($urandom_range(0, 1));
      s = m_busy ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 9) != 0);
      r = ($urandom_range(0, 9) < 6);
      step(v, b, s, r);
    end
    repeat (4) step(0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
